// File: rtl/video_stream_src.sv
// 4-pixel-parallel RGB test-pattern source with line/frame blanking and a frame counter.
// Every output is registered from the next-cycle beat position, so beat 0 follows i_en by one clock.
module video_stream_src #(
    parameter int PARALLEL_NUM = 4,
    parameter int H_ACTIVE     = 1920,
    parameter int V_ACTIVE     = 1080,
    parameter int H_BLANK      = 40,
    parameter int V_BLANK      = 1000
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_en,
    input  logic [1:0]                   i_pattern,
    input  logic [10:0]                  i_box_x0,
    input  logic [10:0]                  i_box_x1,
    input  logic [10:0]                  i_box_y0,
    input  logic [10:0]                  i_box_y1,
    output logic [PARALLEL_NUM-1:0][7:0] o_r,
    output logic [PARALLEL_NUM-1:0][7:0] o_g,
    output logic [PARALLEL_NUM-1:0][7:0] o_b,
    output logic                         o_valid,
    output logic                         o_user,
    output logic                         o_last,
    output logic                         o_busy,
    output logic [15:0]                  o_frame_cnt
);
    localparam int BEATS     = H_ACTIVE / PARALLEL_NUM;
    localparam int BAR_BEATS = H_ACTIVE / (8 * PARALLEL_NUM);

    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

    state_t      state, state_nxt;
    logic [10:0] beat, beat_nxt;
    logic [10:0] line, line_nxt;
    logic [10:0] bar_beat, bar_beat_nxt;
    logic [2:0]  bar, bar_nxt;
    logic [15:0] blank_cnt, blank_cnt_nxt;
    logic [15:0] frame_cnt;
    logic [1:0]  pat_q, pat_nxt;
    logic [10:0] x0_q, x1_q, y0_q, y1_q;
    logic [10:0] x0_nxt, x1_nxt, y0_nxt, y1_nxt;
    logic [7:0]  stamp_q, stamp_nxt;
    logic        emit, start_frame, cnt_inc;
    logic [23:0] pix;
    logic [PARALLEL_NUM-1:0][7:0] r_nxt, g_nxt, b_nxt;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFFFF00;
            3'd2:    return 24'h00FFFF;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'hFF00FF;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // An inverted box (x0>x1 or y0>y1) can never satisfy both bounds, so it is naturally empty.
    function automatic logic [23:0] pixel(
        input logic [1:0]  pat,
        input logic [12:0] x,
        input logic [10:0] y,
        input logic [2:0]  bar_idx,
        input logic [10:0] x0,
        input logic [10:0] x1,
        input logic [10:0] y0,
        input logic [10:0] y1,
        input logic [7:0]  stamp
    );
        logic in_box;
        in_box = ({2'b00, x0} <= x) && (x <= {2'b00, x1}) && (y0 <= y) && (y <= y1);
        case (pat)
            2'd0:    return {3{8'h80}};
            2'd1:    return bar_colour(bar_idx);
            2'd2:    return in_box ? 24'hFFFFFF : 24'h000000;
            default: return {x[7:0], y[7:0], stamp};
        endcase
    endfunction

    always_comb begin
        state_nxt     = state;
        beat_nxt      = beat;
        line_nxt      = line;
        bar_nxt       = bar;
        bar_beat_nxt  = bar_beat;
        blank_cnt_nxt = blank_cnt;
        pat_nxt       = pat_q;
        x0_nxt        = x0_q;
        x1_nxt        = x1_q;
        y0_nxt        = y0_q;
        y1_nxt        = y1_q;
        stamp_nxt     = stamp_q;
        emit          = 1'b0;
        start_frame   = 1'b0;
        cnt_inc       = 1'b0;
        pix           = '0;
        r_nxt         = '0;
        g_nxt         = '0;
        b_nxt         = '0;

        case (state)
            IDLE: start_frame = i_en;
            ACTIVE: begin
                if (beat == 11'(BEATS - 1)) begin
                    state_nxt     = (line == 11'(V_ACTIVE - 1)) ? VBLANK : HBLANK;
                    blank_cnt_nxt = '0;
                end else begin
                    emit     = 1'b1;
                    beat_nxt = beat + 11'd1;
                    if (bar_beat == 11'(BAR_BEATS - 1)) begin
                        bar_beat_nxt = '0;
                        bar_nxt      = bar + 3'd1;
                    end else begin
                        bar_beat_nxt = bar_beat + 11'd1;
                    end
                end
            end
            HBLANK: begin
                if (blank_cnt == 16'(H_BLANK - 1)) begin
                    state_nxt    = ACTIVE;
                    emit         = 1'b1;
                    beat_nxt     = '0;
                    line_nxt     = line + 11'd1;
                    bar_nxt      = '0;
                    bar_beat_nxt = '0;
                end else begin
                    blank_cnt_nxt = blank_cnt + 16'd1;
                end
            end
            VBLANK: begin
                if (blank_cnt == 16'(V_BLANK - 1)) begin
                    if (i_en) start_frame = 1'b1;
                    else      state_nxt   = IDLE;
                end else begin
                    blank_cnt_nxt = blank_cnt + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Frame settings and the ramp stamp are captured only here, at the frame boundary.
        if (start_frame) begin
            state_nxt    = ACTIVE;
            emit         = 1'b1;
            beat_nxt     = '0;
            line_nxt     = '0;
            bar_nxt      = '0;
            bar_beat_nxt = '0;
            pat_nxt      = i_pattern;
            x0_nxt       = i_box_x0;
            x1_nxt       = i_box_x1;
            y0_nxt       = i_box_y0;
            y1_nxt       = i_box_y1;
            stamp_nxt    = frame_cnt[7:0];
        end

        cnt_inc = emit && (beat_nxt == 11'(BEATS - 1)) && (line_nxt == 11'(V_ACTIVE - 1));

        if (emit) begin
            for (int k = 0; k < PARALLEL_NUM; k++) begin
                pix = pixel(pat_nxt, {beat_nxt, 2'b00} + 13'(k), line_nxt, bar_nxt,
                            x0_nxt, x1_nxt, y0_nxt, y1_nxt, stamp_nxt);
                r_nxt[k] = pix[23:16];
                g_nxt[k] = pix[15:8];
                b_nxt[k] = pix[7:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            beat      <= '0;
            line      <= '0;
            bar       <= '0;
            bar_beat  <= '0;
            blank_cnt <= '0;
            frame_cnt <= '0;
            pat_q     <= '0;
            x0_q      <= '0;
            x1_q      <= '0;
            y0_q      <= '0;
            y1_q      <= '0;
            stamp_q   <= '0;
            o_r       <= '0;
            o_g       <= '0;
            o_b       <= '0;
            o_valid   <= 1'b0;
            o_user    <= 1'b0;
            o_last    <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            state     <= state_nxt;
            beat      <= beat_nxt;
            line      <= line_nxt;
            bar       <= bar_nxt;
            bar_beat  <= bar_beat_nxt;
            blank_cnt <= blank_cnt_nxt;
            pat_q     <= pat_nxt;
            x0_q      <= x0_nxt;
            x1_q      <= x1_nxt;
            y0_q      <= y0_nxt;
            y1_q      <= y1_nxt;
            stamp_q   <= stamp_nxt;
            o_r       <= r_nxt;
            o_g       <= g_nxt;
            o_b       <= b_nxt;
            o_valid   <= emit;
            o_user    <= emit && (beat_nxt == '0) && (line_nxt == '0);
            o_last    <= emit && (beat_nxt == 11'(BEATS - 1));
            o_busy    <= (state_nxt != IDLE);
            if (cnt_inc) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign o_frame_cnt = frame_cnt;

endmodule

// File: tb/tb_video_stream_src.sv
// Self-checking bench for video_stream_src on a small 32x4 raster; frame timing and pixels
// come from an arithmetic reference model indexed by the cycle offset within a frame.
module tb_video_stream_src;
    localparam int H_ACTIVE = 32;
    localparam int V_ACTIVE = 4;
    localparam int H_BLANK  = 2;
    localparam int V_BLANK  = 3;
    localparam int BEATS    = H_ACTIVE / 4;
    localparam int LINE_P   = BEATS + H_BLANK;
    localparam int ACT_END  = (V_ACTIVE - 1) * LINE_P + BEATS;
    localparam int FRAME    = ACT_END + V_BLANK;

    localparam logic [23:0] BAR_RGB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    localparam logic [7:0] BAR_R [8] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};
    localparam logic [7:0] BAR_G [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    localparam logic [7:0] BAR_B [8] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};

    typedef struct packed {
        logic [1:0]  pat;
        logic [10:0] x0, x1, y0, y1;
    } cfg_t;

    typedef struct packed {
        logic        valid, user, last, busy;
        logic [15:0] cnt;
        logic [31:0] r, g, b;
    } obs_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic [1:0]      pattern = '0;
    logic [10:0]     bx0 = '0, bx1 = '0, by0 = '0, by1 = '0;
    logic [3:0][7:0] r, g, b;
    logic            valid, user, last, busy;
    logic [15:0]     fcnt;

    int          checks = 0;
    int          passes = 0;
    logic [15:0] exp_cnt = '0;

    video_stream_src #(
        .PARALLEL_NUM(4), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
        .H_BLANK(H_BLANK), .V_BLANK(V_BLANK)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_pattern(pattern),
        .i_box_x0(bx0), .i_box_x1(bx1), .i_box_y0(by0), .i_box_y1(by1),
        .o_r(r), .o_g(g), .o_b(b), .o_valid(valid), .o_user(user), .o_last(last),
        .o_busy(busy), .o_frame_cnt(fcnt)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] ref_pixel(cfg_t c, int x, int y, logic [7:0] fs);
        case (c.pat)
            2'd0: return 24'h808080;
            2'd1: return BAR_RGB[x / (H_ACTIVE / 8)];
            2'd2: return (x >= int'(c.x0) && x <= int'(c.x1) && y >= int'(c.y0) && y <= int'(c.y1))
                         ? 24'hFFFFFF : 24'h000000;
            default: return {8'(x), 8'(y), fs};
        endcase
    endfunction

    // Expected outputs at cycle offset o of a frame that started with frame count c0.
    function automatic obs_t ref_cycle(int o, cfg_t c, logic [15:0] c0);
        obs_t        e;
        int          ln, w;
        logic [23:0] p;
        e      = '0;
        ln     = o / LINE_P;
        w      = o % LINE_P;
        e.busy = 1'b1;
        e.cnt  = (o >= ACT_END - 1) ? c0 + 16'd1 : c0;
        if (o < ACT_END && w < BEATS) begin
            e.valid = 1'b1;
            e.user  = (o == 0);
            e.last  = (w == BEATS - 1);
            for (int k = 0; k < 4; k++) begin
                p = ref_pixel(c, w * 4 + k, ln, c0[7:0]);
                e.r[k*8 +: 8] = p[23:16];
                e.g[k*8 +: 8] = p[15:8];
                e.b[k*8 +: 8] = p[7:0];
            end
        end
        return e;
    endfunction

    function automatic obs_t idle_obs(logic [15:0] c);
        obs_t e;
        e     = '0;
        e.cnt = c;
        return e;
    endfunction

    function automatic obs_t sample();
        return {valid, user, last, busy, fcnt, 32'(r), 32'(g), 32'(b)};
    endfunction

    task automatic drive_cfg(cfg_t c);
        pattern = c.pat;
        bx0 = c.x0; bx1 = c.x1; by0 = c.y0; by1 = c.y1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(busy === 1'b0 && valid === 1'b0) && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy === 1'b0 && valid === 1'b0) passes++;
        else $display("[TB] FAIL wait_idle busy=%b valid=%b after %0d cycles, need 0/0", busy, valid, n);
    endtask

    task automatic test_reset();
        obs_t act;
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (2) @(negedge clk);
        act = sample();
        checks++;
        if (act !== idle_obs(16'h0)) $display("[TB] FAIL reset_state act=%h exp=%h", act, idle_obs(16'h0));
        else passes++;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            act = sample();
            checks++;
            if (act !== idle_obs(16'h0)) $display("[TB] FAIL idle_no_en i=%0d act=%h exp=%h", i, act, idle_obs(16'h0));
            else passes++;
        end
    endtask

    // Three back-to-back gray frames; i_en drops during line 2 of the third so it is the last.
    task automatic test_timing();
        cfg_t c;
        obs_t act, exp;
        int   f, o;
        c = '0;
        drive_cfg(c);
        en = 1'b1;
        for (int n = 0; n < 3 * FRAME + 6; n++) begin
            @(negedge clk);
            f   = n / FRAME;
            o   = n % FRAME;
            act = sample();
            exp = (f < 3) ? ref_cycle(o, c, exp_cnt + 16'(f)) : idle_obs(exp_cnt + 16'd3);
            checks++;
            if (act !== exp) $display("[TB] FAIL timing n=%0d act=%h exp=%h", n, act, exp);
            else passes++;
            if (n == 2 * FRAME + 2 * LINE_P + 3) en = 1'b0;
        end
        exp_cnt = exp_cnt + 16'd3;
    endtask

    task automatic test_bars();
        cfg_t c;
        c = '0;
        c.pat = 2'd1;
        drive_cfg(c);
        en = 1'b1;
        for (int o = 0; o < FRAME; o++) begin
            @(negedge clk);
            en = 1'b0;
            if (o < BEATS) begin
                checks++;
                if ({r, g, b} !== {{4{BAR_R[o]}}, {4{BAR_G[o]}}, {4{BAR_B[o]}}})
                    $display("[TB] FAIL bars beat=%0d act=%h_%h_%h exp=%h_%h_%h", o, r, g, b,
                             {4{BAR_R[o]}}, {4{BAR_G[o]}}, {4{BAR_B[o]}});
                else passes++;
            end
            if (o == 1) begin
                checks++;
                if (r !== 32'hFFFFFFFF || g !== 32'hFFFFFFFF || b !== 32'h0)
                    $display("[TB] FAIL bars_yellow act=%h_%h_%h exp=ffffffff_ffffffff_00000000", r, g, b);
                else passes++;
            end
        end
        exp_cnt = exp_cnt + 16'd1;
        wait_idle();
    endtask

    task automatic test_box();
        cfg_t c;
        c.pat = 2'd2; c.x0 = 11'd5; c.x1 = 11'd10; c.y0 = 11'd1; c.y1 = 11'd2;
        drive_cfg(c);
        en = 1'b1;
        for (int o = 0; o < FRAME; o++) begin
            @(negedge clk);
            en = 1'b0;
            if (o == LINE_P + 1) begin
                checks++;
                if ({r, g, b} !== {3{32'hFFFFFF00}}) $display("[TB] FAIL box_l1b1 act=%h_%h_%h exp=ffffff00", r, g, b);
                else passes++;
            end
            if (o == LINE_P + 2) begin
                checks++;
                if ({r, g, b} !== {3{32'h00FFFFFF}}) $display("[TB] FAIL box_l1b2 act=%h_%h_%h exp=00ffffff", r, g, b);
                else passes++;
            end
            if (o < BEATS || (o >= 3 * LINE_P && o < ACT_END)) begin
                checks++;
                if (valid !== 1'b1 || {r, g, b} !== 96'h0)
                    $display("[TB] FAIL box_empty_line o=%0d valid=%b act=%h_%h_%h exp=1 zero", o, valid, r, g, b);
                else passes++;
            end
        end
        exp_cnt = exp_cnt + 16'd1;
        wait_idle();
    endtask

    // Back-to-back random frames; inputs are scrambled mid-frame and must not leak in.
    task automatic test_random_frames();
        cfg_t        cf [7];
        obs_t        act, exp;
        logic [15:0] c0;
        c0 = exp_cnt;
        for (int f = 0; f < 7; f++) begin
            cf[f].pat = 2'(f % 4);
            cf[f].x0  = 11'($urandom_range(0, 35));
            cf[f].x1  = 11'($urandom_range(0, 35));
            cf[f].y0  = 11'($urandom_range(0, 4));
            cf[f].y1  = 11'($urandom_range(0, 4));
        end
        drive_cfg(cf[0]);
        en = 1'b1;
        for (int f = 0; f < 6; f++) begin
            for (int o = 0; o < FRAME; o++) begin
                @(negedge clk);
                act = sample();
                exp = ref_cycle(o, cf[f], c0);
                checks++;
                if (act !== exp) $display("[TB] FAIL random f=%0d o=%0d act=%h exp=%h", f, o, act, exp);
                else passes++;
                if (o == 15) begin
                    pattern = 2'($urandom_range(0, 3));
                    bx0 = 11'($urandom); bx1 = 11'($urandom);
                    by0 = 11'($urandom); by1 = 11'($urandom);
                    en  = 1'($urandom_range(0, 1));
                end
                if (o == FRAME - 2) begin
                    drive_cfg(cf[f+1]);
                    en = (f < 5);
                end
            end
            c0 = c0 + 16'd1;
        end
        exp_cnt = c0;
        wait_idle();
    endtask

    task automatic test_reset_midframe();
        cfg_t c;
        obs_t act, exp;
        c.pat = 2'd3; c.x0 = '0; c.x1 = '0; c.y0 = '0; c.y1 = '0;
        drive_cfg(c);
        en = 1'b1;
        for (int o = 0; o <= LINE_P + 4; o++) @(negedge clk);
        act = sample();
        exp = ref_cycle(LINE_P + 4, c, exp_cnt);
        checks++;
        if (act !== exp) $display("[TB] FAIL pre_reset_beat act=%h exp=%h", act, exp);
        else passes++;
        rst_n = 1'b0;
        #1;
        act = sample();
        checks++;
        if (act !== idle_obs(16'h0)) $display("[TB] FAIL reset_same_cycle act=%h exp=%h", act, idle_obs(16'h0));
        else passes++;
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = '0;
        for (int o = 0; o < FRAME; o++) begin
            @(negedge clk);
            en  = 1'b0;
            act = sample();
            exp = ref_cycle(o, c, exp_cnt);
            checks++;
            if (act !== exp) $display("[TB] FAIL after_reset o=%0d act=%h exp=%h", o, act, exp);
            else passes++;
        end
        exp_cnt = exp_cnt + 16'd1;
        wait_idle();
    endtask

    task automatic test_wrap();
        cfg_t c;
        obs_t act, exp;
        c.pat = 2'd3; c.x0 = '0; c.x1 = '0; c.y0 = '0; c.y1 = '0;
        force dut.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt;
        @(negedge clk);
        checks++;
        if (fcnt !== 16'hFFFF) $display("[TB] FAIL wrap_preload act=%h exp=ffff", fcnt);
        else passes++;
        drive_cfg(c);
        en = 1'b1;
        for (int o = 0; o < FRAME; o++) begin
            @(negedge clk);
            en  = 1'b0;
            act = sample();
            exp = ref_cycle(o, c, 16'hFFFF);
            checks++;
            if (act !== exp) $display("[TB] FAIL wrap o=%0d act=%h exp=%h", o, act, exp);
            else passes++;
        end
        wait_idle();
        checks++;
        if (fcnt !== 16'h0000) $display("[TB] FAIL wrap_final act=%h exp=0000", fcnt);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_timing();
        test_bars();
        test_box();
        test_random_frames();
        test_reset_midframe();
        test_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
